ddr4_dqs_dir_tracker: RTL



---
 rtl/ddr4_dqs_dir_tracker.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/ddr4_dqs_dir_tracker.sv
// ddr4_dqs_dir_tracker
// Per-lane DQS direction tracker for the DDR4 RDIMM simulation wrapper.
// Each lane decides whether the controller (write) or the memory (read) owns
// DQS, qualifies bursts with a preamble count, holds them through a postamble,
// and raises sticky contention/timeout flags plus lane-0 burst statistics.
module ddr4_dqs_dir_tracker #(
  parameter int unsigned NUM_LANES = 9,
  parameter int unsigned PRE_CYC   = 2,
  parameter int unsigned POST_CYC  = 2,
  parameter int unsigned MAX_BURST = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_LANES-1:0] mc_dqs_t,
  input  logic [NUM_LANES-1:0] mc_dqs_c,
  input  logic [NUM_LANES-1:0] mem_dqs_t,
  input  logic [NUM_LANES-1:0] mem_dqs_c,
  input  logic                 clr,
  output logic [NUM_LANES-1:0] wr_drive,
  output logic [NUM_LANES-1:0] rd_drive,
  output logic [NUM_LANES-1:0] err_conflict,
  output logic [NUM_LANES-1:0] err_timeout,
  output logic                 lane_mismatch,
  output logic [15:0]          wr_bursts,
  output logic [15:0]          rd_bursts
);

  localparam int unsigned PC_W  = (PRE_CYC   < 2) ? 1 : $clog2(PRE_CYC + 1);
  localparam int unsigned QC_W  = (POST_CYC  < 2) ? 1 : $clog2(POST_CYC + 1);
  localparam int unsigned RES_W = $clog2(MAX_BURST + 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WR_PRE   = 3'd1,
    S_RD_PRE   = 3'd2,
    S_WR       = 3'd3,
    S_RD       = 3'd4,
    S_CONFLICT = 3'd5
  } state_e;

  state_e            state_q [NUM_LANES];
  state_e            state_d [NUM_LANES];
  logic [PC_W-1:0]   pc_q    [NUM_LANES];
  logic [PC_W-1:0]   pc_d    [NUM_LANES];
  logic [QC_W-1:0]   qc_q    [NUM_LANES];
  logic [QC_W-1:0]   qc_d    [NUM_LANES];
  logic [RES_W-1:0]  res_q   [NUM_LANES];
  logic [RES_W-1:0]  res_d   [NUM_LANES];

  logic [NUM_LANES-1:0] mc_drv;
  logic [NUM_LANES-1:0] mem_drv;
  logic [NUM_LANES-1:0] conf_evt;
  logic [NUM_LANES-1:0] tmo_evt;
  logic [NUM_LANES-1:0] wr_drive_d;
  logic [NUM_LANES-1:0] rd_drive_d;
  logic                 mismatch_d;
  logic                 wr_entry;
  logic                 rd_entry;

  // Pair activity: equal legs (including matching X/Z) read as idle.
  always_comb begin
    for (int unsigned l = 0; l < NUM_LANES; l++) begin
      mc_drv[l]  = (mc_dqs_t[l]  !== mc_dqs_c[l]);
      mem_drv[l] = (mem_dqs_t[l] !== mem_dqs_c[l]);
    end
  end

  // Next-state, counters and error events for every lane.
  always_comb begin
    for (int unsigned l = 0; l < NUM_LANES; l++) begin
      state_d[l]  = state_q[l];
      pc_d[l]     = pc_q[l];
      qc_d[l]     = qc_q[l];
      res_d[l]    = res_q[l];
      conf_evt[l] = 1'b0;
      tmo_evt[l]  = 1'b0;

      case (state_q[l])
        S_IDLE: begin
          pc_d[l] = '0;
          qc_d[l] = '0;
          if (mc_drv[l] && mem_drv[l]) begin
            state_d[l]  = S_CONFLICT;
            conf_evt[l] = 1'b1;
          end else if (mc_drv[l]) begin
            state_d[l] = (PRE_CYC <= 1) ? S_WR : S_WR_PRE;
            pc_d[l]    = PC_W'(1);
          end else if (mem_drv[l]) begin
            state_d[l] = (PRE_CYC <= 1) ? S_RD : S_RD_PRE;
            pc_d[l]    = PC_W'(1);
          end
        end

        S_WR_PRE, S_RD_PRE: begin
          if (mc_drv[l] && mem_drv[l]) begin
            state_d[l]  = S_CONFLICT;
            conf_evt[l] = 1'b1;
            qc_d[l]     = '0;
          end else if ((state_q[l] == S_WR_PRE) ? mc_drv[l] : mem_drv[l]) begin
            if (32'(pc_q[l]) + 32'd1 >= PRE_CYC) begin
              state_d[l] = (state_q[l] == S_WR_PRE) ? S_WR : S_RD;
              qc_d[l]    = '0;
            end else begin
              pc_d[l] = pc_q[l] + PC_W'(1);
            end
          end else begin
            state_d[l] = S_IDLE;
          end
        end

        S_WR, S_RD, S_CONFLICT: begin
          // Far side echoes the driven side here, so only postamble matters.
          if (!mc_drv[l] && !mem_drv[l]) begin
            if (32'(qc_q[l]) + 32'd1 >= POST_CYC) begin
              state_d[l] = S_IDLE;
              qc_d[l]    = '0;
            end else begin
              qc_d[l] = qc_q[l] + QC_W'(1);
            end
          end else begin
            qc_d[l] = '0;
          end
        end

        default: begin
          state_d[l] = S_IDLE;
          pc_d[l]    = '0;
          qc_d[l]    = '0;
        end
      endcase

      // Residency counts edges spent staying in WR/RD; any exit clears it.
      if (state_q[l] == S_WR || state_q[l] == S_RD) begin
        if (state_d[l] == state_q[l]) begin
          if (32'(res_q[l]) < MAX_BURST) begin
            res_d[l] = res_q[l] + RES_W'(1);
            if (32'(res_q[l]) + 32'd1 == MAX_BURST) begin
              tmo_evt[l] = 1'b1;
            end
          end
        end else begin
          res_d[l] = '0;
        end
      end else begin
        res_d[l] = '0;
      end
    end
  end

  // Drive enables and lane disagreement decoded from next state.
  always_comb begin
    for (int unsigned l = 0; l < NUM_LANES; l++) begin
      wr_drive_d[l] = (state_d[l] == S_WR);
      rd_drive_d[l] = (state_d[l] == S_RD);
    end
    mismatch_d = (|wr_drive_d) && (|rd_drive_d);
    wr_entry   = (state_d[0] == S_WR) && (state_q[0] != S_WR);
    rd_entry   = (state_d[0] == S_RD) && (state_q[0] != S_RD);
  end

  // Per-lane state and counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned l = 0; l < NUM_LANES; l++) begin
        state_q[l] <= S_IDLE;
        pc_q[l]    <= '0;
        qc_q[l]    <= '0;
        res_q[l]   <= '0;
      end
    end else begin
      for (int unsigned l = 0; l < NUM_LANES; l++) begin
        state_q[l] <= state_d[l];
        pc_q[l]    <= pc_d[l];
        qc_q[l]    <= qc_d[l];
        res_q[l]   <= res_d[l];
      end
    end
  end

  // Registered outputs; a new error event wins over a same-cycle clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_drive      <= '0;
      rd_drive      <= '0;
      lane_mismatch <= 1'b0;
      err_conflict  <= '0;
      err_timeout   <= '0;
    end else begin
      wr_drive      <= wr_drive_d;
      rd_drive      <= rd_drive_d;
      lane_mismatch <= mismatch_d;
      err_conflict  <= (err_conflict & ~{NUM_LANES{clr}}) | conf_evt;
      err_timeout   <= (err_timeout  & ~{NUM_LANES{clr}}) | tmo_evt;
    end
  end

  // Saturating lane-0 burst statistics; clear dominates an increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_bursts <= '0;
      rd_bursts <= '0;
    end else if (clr) begin
      wr_bursts <= '0;
      rd_bursts <= '0;
    end else begin
      if (wr_entry && wr_bursts != 16'hFFFF) begin
        wr_bursts <= wr_bursts + 16'd1;
      end
      if (rd_entry && rd_bursts != 16'hFFFF) begin
        rd_bursts <= rd_bursts + 16'd1;
      end
    end
  end

endmodule
